laser_beacon_tx: RTL and testbench
==================================

LASER_BEACON_TX -- requirements
Module: laser_beacon_tx

Interface
REQ-001 SHALL have parameter CARRIER_DIV, default 25: carrier half-period in clk cycles (min 1).
REQ-002 SHALL have parameter CARRIERS_PER_BIT, default 8: carrier periods per bit slot (min 1).
REQ-003 SHALL have parameter GAP_SLOTS, default 4: dark slots appended after each frame (min 0).
REQ-004 SHALL have port clk, input, 1: system clock, all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port tx_valid, input, 1: frame request.
REQ-007 SHALL have port tx_data, input, 8: beacon ID to send.
REQ-008 SHALL have port tx_ready, output, 1: high only in IDLE; request accepted on tx_valid & tx_ready.
REQ-009 SHALL have port laser_out, output, 1: registered laser drive, 1 = emitter on.
REQ-010 SHALL have port tx_done, output, 1: one-cycle pulse at end of frame.
REQ-011 SHALL have port busy, output, 1: equal to !tx_ready.

Function
REQ-012 SHALL define slot length S = 2*CARRIER_DIV*CARRIERS_PER_BIT clk cycles.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP, GAP.
REQ-014 SHALL encode on-off keyed: "on" slot = carrier, "dark" slot = laser_out held 0.
REQ-015 SHALL, in an on slot, drive laser_out 1 for the first CARRIER_DIV cycles, then toggle every CARRIER_DIV cycles; carrier phase restarts at every slot boundary.
REQ-016 SHALL, on acceptance in IDLE, latch tx_data and enter START on the next clk; first START cycle drives laser_out 1.
REQ-017 SHALL send START as one on slot, then 8 DATA slots MSB first (1 = on, 0 = dark), then PARITY (if enabled), then STOP as one dark slot, then GAP_SLOTS dark slots.
REQ-018 SHALL skip GAP when GAP_SLOTS = 0, going from STOP directly to IDLE.
REQ-019 SHALL pulse tx_done on the last cycle of the frame (last GAP cycle, or last STOP cycle if GAP_SLOTS = 0); tx_ready rises the following cycle.
REQ-020 SHALL ignore tx_valid and tx_data while busy; latched data SHALL not change mid-frame.
REQ-021 SHALL accept a new request on the first IDLE cycle if tx_valid is held, giving back-to-back frames separated by exactly one idle cycle.
REQ-022 SHALL size slot, carrier and bit counters to hold their maximum values without wrap; no counter wraps except by explicit reload at slot end.
REQ-023 SHALL hold laser_out 0 in IDLE, STOP and GAP.

Reset
REQ-024 SHALL, on rstn low, asynchronously force state IDLE, laser_out 0, tx_done 0, tx_ready 1 after reset release, counters 0, data register 0.
REQ-025 SHALL abort any frame in progress on reset without emitting tx_done.
REQ-026 SHALL not accept a request in the same cycle rstn deasserts; first acceptance on the first clk edge with rstn high.

Configuration
REQ-027 SHALL compile in a PARITY slot only when macro LASER_BEACON_PARITY_EN is defined: one slot after DATA, on if the XOR of the 8 data bits is 1 (even parity over data+parity).
REQ-028 SHALL, without LASER_BEACON_PARITY_EN, omit the PARITY state entirely; DATA goes directly to STOP.

Verification (CARRIER_DIV=2, CARRIERS_PER_BIT=2, GAP_SLOTS=1, S=8)
REQ-029 SHALL check: tx_data=0xA5, no parity -> laser_out slots on,1,0,1,0,0,1,0,1,dark,dark (11 slots, 88 cycles); tx_done at cycle 88 after acceptance; each on slot pattern 1,1,0,0,1,1,0,0.
REQ-030 SHALL check: LASER_BEACON_PARITY_EN, tx_data=0x01 -> 12 slots, parity slot on, tx_done at cycle 96.
REQ-031 SHALL check: tx_valid held high with 0xFF then 0x00 -> second START begins exactly 2 cycles after first tx_done pulse cycle; tx_ready high for one cycle between frames.
REQ-032 SHALL check: rstn pulsed low at cycle 30 of a frame -> laser_out 0 within same cycle, no tx_done, tx_ready 1 after release, next frame correct.
REQ-033 SHALL check: tx_data changed and tx_valid toggled mid-frame -> transmitted bits unchanged, no second acceptance until tx_ready.
REQ-034 SHALL check: GAP_SLOTS=0, tx_data=0x00 -> START on slot, 9 dark slots, tx_done on last STOP cycle (cycle 80).

Source files
------------

// File: rtl/laser_beacon_tx.sv
// laser_beacon_tx: on-off keyed laser beacon frame transmitter (START, 8 data MSB first, optional parity, STOP, GAP).
// Define LASER_BEACON_PARITY_EN to add an even-parity slot after the data bits.
module laser_beacon_tx #(
  parameter int CARRIER_DIV      = 25,
  parameter int CARRIERS_PER_BIT = 8,
  parameter int GAP_SLOTS        = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       laser_out,
  output logic       tx_done,
  output logic       busy
);
  localparam int S  = 2 * CARRIER_DIV * CARRIERS_PER_BIT;
  localparam int SW = $clog2(S);
  localparam int CW = $clog2(CARRIER_DIV + 1);
  localparam int BW = $clog2((GAP_SLOTS > 8 ? GAP_SLOTS : 8) + 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef LASER_BEACON_PARITY_EN
    PARITY,
`endif
    STOP, GAP
  } state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [CW-1:0] car_q, car_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          ph_q, ph_d, laser_q, laser_d, done_q, done_d, ready_q, ready_d;
  logic          slot_end, par_on, last_d;
  assign slot_end = slot_q == SW'(S - 1);
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    car_d   = car_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    data_d  = data_q;
    if (state_q == IDLE) begin
      if (tx_valid) begin
        state_d = START;
        data_d  = tx_data;
        slot_d  = '0;
        car_d   = '0;
        bit_d   = '0;
        ph_d    = 1'b1;
      end
    end else if (slot_end) begin
      // carrier phase restarts high at every slot boundary
      slot_d = '0;
      car_d  = '0;
      ph_d   = 1'b1;
      bit_d  = '0;
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          bit_d = bit_q + 1'b1;
`ifdef LASER_BEACON_PARITY_EN
          if (bit_q == BW'(7)) state_d = PARITY;
`else
          if (bit_q == BW'(7)) state_d = STOP;
`endif
        end
`ifdef LASER_BEACON_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: state_d = GAP_SLOTS == 0 ? IDLE : GAP;
        GAP: begin
          bit_d   = bit_q + 1'b1;
          state_d = bit_q == BW'(GAP_SLOTS - 1) ? IDLE : GAP;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      slot_d = slot_q + 1'b1;
      car_d  = car_q == CW'(CARRIER_DIV - 1) ? '0 : car_q + 1'b1;
      ph_d   = car_q == CW'(CARRIER_DIV - 1) ? ~ph_q : ph_q;
    end
`ifdef LASER_BEACON_PARITY_EN
    par_on = state_d == PARITY && ^data_d;
`else
    par_on = 1'b0;
`endif
    laser_d = ph_d && (state_d == START || (state_d == DATA && data_d[~bit_d[2:0]]) || par_on);
    last_d  = GAP_SLOTS == 0 ? state_d == STOP : (state_d == GAP && bit_d == BW'(GAP_SLOTS - 1));
    done_d  = last_d && slot_d == SW'(S - 1);
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      slot_q  <= '0;
      car_q   <= '0;
      bit_q   <= '0;
      ph_q    <= 1'b0;
      data_q  <= '0;
      laser_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      car_q   <= car_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      data_q  <= data_d;
      laser_q <= laser_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end
  assign laser_out = laser_q;
  assign tx_done   = done_q;
  assign tx_ready  = ready_q;
  assign busy      = ~ready_q;
endmodule

// File: tb/tb_laser_beacon_tx.sv
// tb_laser_beacon_tx: directed checks of laser_beacon_tx with CARRIER_DIV=2, CARRIERS_PER_BIT=2 (slot = 8 cycles).
module tb_laser_beacon_tx;
`ifdef LASER_BEACON_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NF  = PAR ? 96 : 88;
  localparam int NF0 = PAR ? 88 : 80;
  logic       clk = 0, rstn = 0, v0 = 0, v1 = 0, sel = 0;
  logic [7:0] d0 = 0, d1 = 0;
  logic       r0, l0, dn0, b0, r1, l1, dn1, b1, lo, dno, ro, bo;
  int         total = 0, bad = 0;
  laser_beacon_tx #(.CARRIER_DIV(2), .CARRIERS_PER_BIT(2), .GAP_SLOTS(1)) dut (
    .clk(clk), .rstn(rstn), .tx_valid(v0), .tx_data(d0),
    .tx_ready(r0), .laser_out(l0), .tx_done(dn0), .busy(b0));
  laser_beacon_tx #(.CARRIER_DIV(2), .CARRIERS_PER_BIT(2), .GAP_SLOTS(0)) dut_g0 (
    .clk(clk), .rstn(rstn), .tx_valid(v1), .tx_data(d1),
    .tx_ready(r1), .laser_out(l1), .tx_done(dn1), .busy(b1));
  assign lo  = sel ? l1 : l0;
  assign dno = sel ? dn1 : dn0;
  assign ro  = sel ? r1 : r0;
  assign bo  = sel ? b1 : b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  // expected laser level at frame cycle k (1 = first START cycle)
  function automatic logic exp_laser(input logic [7:0] d, input int k);
    int  s = (k - 1) / 8;
    int  p = (k - 1) % 8;
    logic on = s == 0 ? 1'b1 : s <= 8 ? d[8 - s] : (PAR && s == 9) ? ^d : 1'b0;
    return on && ((p / 2) % 2 == 0);
  endfunction
  task automatic set_valid(input logic v);
    if (sel) v1 = v; else v0 = v;
  endtask
  task automatic set_data(input logic [7:0] d);
    if (sel) d1 = d; else d0 = d;
  endtask
  task automatic run_frame(input string tag, input logic [7:0] d, input int n, input bit hold,
                           input logic [7:0] nxt, input bit mutate);
    int errs = 0, done_at = 0, ndone = 0, rdy_hi = 0;
    @(posedge clk);
    #1 set_valid(hold);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (lo !== exp_laser(d, k)) errs++;
      if (bo !== 1'b1) errs++;
      if (dno) begin ndone++; done_at = k; end
      if (ro) rdy_hi++;
      if (k == 10) set_data(nxt);
      if (mutate && k == 20) set_valid(1'b1);
      if (mutate && k == 24) set_valid(hold);
    end
    chk({tag, "_laser"}, errs, 0);
    chk({tag, "_done_at"}, done_at, n);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_ready_busy"}, rdy_hi, 0);
    @(negedge clk);
    chk({tag, "_ready_after"}, ro, 1);
    chk({tag, "_idle_laser"}, {lo, dno}, 0);
  endtask
  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_laser", l0, 0);
    chk("rst_done", dn0, 0);
    chk("rst_ready", r0, 1);
    v0 = 1; d0 = 8'hA5;
    @(negedge clk);
    rstn = 1;
    run_frame("a5", 8'hA5, NF, 0, 8'h00, 0);
    @(negedge clk);
    v0 = 1; d0 = 8'h01;
    run_frame("p01", 8'h01, NF, 0, 8'h00, 0);
    @(negedge clk);
    v0 = 1; d0 = 8'hFF;
    run_frame("ff", 8'hFF, NF, 1, 8'h00, 0);
    run_frame("b2b00", 8'h00, NF, 0, 8'h00, 0);
    @(negedge clk);
    v0 = 1; d0 = 8'h3C;
    run_frame("mut", 8'h3C, NF, 0, 8'hC3, 1);
    @(negedge clk);
    v0 = 1; d0 = 8'hA5;
    @(posedge clk);
    #1 v0 = 0;
    repeat (30) @(negedge clk);
    chk("pre_rst_laser", l0, 1);
    #1 rstn = 0;
    #1 chk("rst_async_laser", l0, 0);
    chk("rst_async_done", dn0, 0);
    @(negedge clk);
    rstn = 1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dn0 || !r0 || l0) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    v0 = 1; d0 = 8'h5A;
    run_frame("post_rst", 8'h5A, NF, 0, 8'h00, 0);
    sel = 1;
    @(negedge clk);
    v1 = 1; d1 = 8'h00;
    run_frame("gap0", 8'h00, NF0, 0, 8'hFF, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
